gemm_tile_writeback: RTL and testbench

Output writeback stage for the tiled GeMM accelerator. It sits directly downstream of the RowPar×ColPar PE array and captures one completed output tile per handshake. It then drains the tile, one element per cycle in row-major order, to the single-port SRAM C write port. Elements that fall outside the M×N matrix are masked, and the stage applies back-pressure from the SRAM grant.

---
 rtl/gemm_pkg.sv | 21 ++
 rtl/gemm_tile_writeback.sv | 108 ++++++++++
 tb/tb_gemm_tile_writeback.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gemm_pkg.sv
// Shared types and default sizing for the tiled GeMM accelerator.
// Writeback-stage states plus a helper for counter widths.
package gemm_pkg;

    localparam int OUT_DATA_WIDTH  = 32;
    localparam int ADDR_WIDTH      = 16;
    localparam int SIZE_ADDR_WIDTH = 8;
    localparam int ROW_PAR         = 4;
    localparam int COL_PAR         = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } wb_state_e;

    // Index width that stays legal when a dimension collapses to 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gemm_tile_writeback.sv
// Captures one RowPar x ColPar output tile and drains it row-major to the
// SRAM C write port, masking slots outside the M x N matrix.
module gemm_tile_writeback
    import gemm_pkg::*;
#(
    parameter int OutDataWidth  = OUT_DATA_WIDTH,
    parameter int AddrWidth     = ADDR_WIDTH,
    parameter int SizeAddrWidth = SIZE_ADDR_WIDTH,
    parameter int RowPar        = ROW_PAR,
    parameter int ColPar        = COL_PAR
) (
    input  logic                                             clk_i,
    input  logic                                             rst_ni,
    input  logic [SizeAddrWidth-1:0]                         M_size_i,
    input  logic [SizeAddrWidth-1:0]                         N_size_i,
    input  logic                                             tile_valid_i,
    output logic                                             tile_ready_o,
    input  logic [RowPar-1:0][ColPar-1:0][OutDataWidth-1:0]  tile_data_i,
    input  logic [SizeAddrWidth-1:0]                         tile_row_base_i,
    input  logic [SizeAddrWidth-1:0]                         tile_col_base_i,
    output logic [AddrWidth-1:0]                             sram_c_addr_o,
    output logic [OutDataWidth-1:0]                          sram_c_wdata_o,
    output logic                                             sram_c_we_o,
    input  logic                                             sram_c_gnt_i,
    output logic                                             busy_o,
    output logic                                             tile_done_o
);

    localparam int RowW = cnt_width(RowPar);
    localparam int ColW = cnt_width(ColPar);
    localparam int SumW = SizeAddrWidth + 1;

    // Handshake: a tile moves on a clk_i edge where tile_valid_i && tile_ready_o;
    // an SRAM write completes on an edge where sram_c_we_o && sram_c_gnt_i.
    wb_state_e state_q, state_d;

    logic [RowPar-1:0][ColPar-1:0][OutDataWidth-1:0] buf_q;
    logic [SizeAddrWidth-1:0] row_base_q, col_base_q;
    logic [RowW-1:0]          row_q;
    logic [ColW-1:0]          col_q;
    logic                     done_q;

    logic [SumW-1:0] row_sum, col_sum;
    logic            in_bounds, retire, last_slot, last_retire, accept;

    // One extra bit keeps base+offset from wrapping before the bound check.
    assign row_sum = {1'b0, row_base_q} + SumW'(row_q);
    assign col_sum = {1'b0, col_base_q} + SumW'(col_q);

    always_comb begin
        state_d      = state_q;
        in_bounds    = (row_sum < {1'b0, M_size_i}) && (col_sum < {1'b0, N_size_i});
        last_slot    = (row_q == RowW'(RowPar - 1)) && (col_q == ColW'(ColPar - 1));
        retire       = (state_q == DRAIN) && (!in_bounds || sram_c_gnt_i);
        last_retire  = retire && last_slot;
        tile_ready_o = (state_q == IDLE) || last_retire;
        accept       = tile_valid_i && tile_ready_o;
        sram_c_we_o  = (state_q == DRAIN) && in_bounds;
        busy_o       = (state_q == DRAIN);

        if (accept) begin
            state_d = DRAIN;
        end else if (last_retire) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_q      <= '0;
            row_base_q <= '0;
            col_base_q <= '0;
            row_q      <= '0;
            col_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= last_retire;
            if (accept) begin
                buf_q      <= tile_data_i;
                row_base_q <= tile_row_base_i;
                col_base_q <= tile_col_base_i;
                row_q      <= '0;
                col_q      <= '0;
            end else if (retire) begin
                if (col_q == ColW'(ColPar - 1)) begin
                    col_q <= '0;
                    row_q <= last_slot ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    // Address wraps modulo 2^AddrWidth, same as truncating the full product.
    assign sram_c_addr_o  = AddrWidth'(row_sum) * AddrWidth'(N_size_i) + AddrWidth'(col_sum);
    assign sram_c_wdata_o = buf_q[row_q][col_q];
    assign tile_done_o    = done_q;

endmodule

// File: tb/tb_gemm_tile_writeback.sv
// Self-checking bench for gemm_tile_writeback: scoreboard of expected SRAM writes
// plus drain-timing, back-pressure, back-to-back and reset checks.
module tb_gemm_tile_writeback;

    localparam int W  = 32;
    localparam int AW = 16;
    localparam int SW = 8;
    localparam int RP = 4;
    localparam int CP = 16;
    localparam int SLOTS = RP * CP;

    logic                         clk_i = 1'b0;
    logic                         rst_ni;
    logic [SW-1:0]                M_size_i, N_size_i;
    logic                         tile_valid_i;
    logic                         tile_ready_o;
    logic [RP-1:0][CP-1:0][W-1:0] tile_data_i;
    logic [SW-1:0]                tile_row_base_i, tile_col_base_i;
    logic [AW-1:0]                sram_c_addr_o;
    logic [W-1:0]                 sram_c_wdata_o;
    logic                         sram_c_we_o;
    logic                         sram_c_gnt_i;
    logic                         busy_o;
    logic                         tile_done_o;

    gemm_tile_writeback dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .M_size_i        (M_size_i),
        .N_size_i        (N_size_i),
        .tile_valid_i    (tile_valid_i),
        .tile_ready_o    (tile_ready_o),
        .tile_data_i     (tile_data_i),
        .tile_row_base_i (tile_row_base_i),
        .tile_col_base_i (tile_col_base_i),
        .sram_c_addr_o   (sram_c_addr_o),
        .sram_c_wdata_o  (sram_c_wdata_o),
        .sram_c_we_o     (sram_c_we_o),
        .sram_c_gnt_i    (sram_c_gnt_i),
        .busy_o          (busy_o),
        .tile_done_o     (tile_done_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [AW+W-1:0] exp_q[$];
    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;
    int unsigned write_cnt = 0;
    int unsigned done_cnt = 0;
    int unsigned cap_cyc = 0;
    logic [RP-1:0][CP-1:0][W-1:0] last_tile;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Write monitor: every granted write must match the head of the queue.
    always @(negedge clk_i) begin
        logic [AW+W-1:0] e;
        if (rst_ni === 1'b1) begin
            if (sram_c_we_o && sram_c_gnt_i) begin
                write_cnt++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_write", 64'(sram_c_addr_o), 64'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("wr_addr", 64'(sram_c_addr_o), 64'(e[AW+W-1:W]));
                    check_eq("wr_data", 64'(sram_c_wdata_o), 64'(e[W-1:0]));
                end
            end
            if (tile_done_o) done_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_tile(input int m, input int n, input int rb, input int cb,
                             output int waited);
        logic ok;
        int   addr;
        M_size_i        = SW'(m);
        N_size_i        = SW'(n);
        tile_row_base_i = SW'(rb);
        tile_col_base_i = SW'(cb);
        for (int r = 0; r < RP; r++)
            for (int c = 0; c < CP; c++)
                tile_data_i[r][c] = $urandom;
        last_tile    = tile_data_i;
        tile_valid_i = 1'b1;
        for (int r = 0; r < RP; r++)
            for (int c = 0; c < CP; c++)
                if ((rb + r) < m && (cb + c) < n) begin
                    addr = ((rb + r) * n + cb + c) & 32'hFFFF;
                    exp_q.push_back({AW'(addr), tile_data_i[r][c]});
                end
        waited = 0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (tile_ready_o) begin
                ok = 1'b1;
                break;
            end
            waited++;
        end
        if (!ok) begin
            check_eq("handshake_timeout", 64'(0), 64'(1));
        end else begin
            cap_cyc = cyc + 1;
            @(posedge clk_i);
            #1;
            for (int r = 0; r < RP; r++)
                for (int c = 0; c < CP; c++)
                    tile_data_i[r][c] = $urandom;
        end
    endtask

    task automatic wait_done(input string tag, input int exp_delta);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (tile_done_o && cyc > cap_cyc) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq({tag, "_done_timeout"}, 64'(0), 64'(1));
        else     check_eq({tag, "_done_cycle"}, 64'(cyc - cap_cyc), 64'(exp_delta));
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int unsigned w0, d0;
        int waited;

        rst_ni          = 1'b0;
        tile_valid_i    = 1'b0;
        sram_c_gnt_i    = 1'b1;
        M_size_i        = '0;
        N_size_i        = '0;
        tile_row_base_i = '0;
        tile_col_base_i = '0;
        tile_data_i     = '0;
        #1;
        check_eq("rst_ready", 64'(tile_ready_o), 64'(1));
        check_eq("rst_we",    64'(sram_c_we_o),  64'(0));
        check_eq("rst_busy",  64'(busy_o),       64'(0));
        check_eq("rst_done",  64'(tile_done_o),  64'(0));
        check_eq("rst_addr",  64'(sram_c_addr_o), 64'(0));
        check_eq("rst_wdata", 64'(sram_c_wdata_o), 64'(0));
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Full in-bounds tile: 64 writes, done 64 edges after capture.
        w0 = write_cnt; d0 = done_cnt;
        send_tile(4, 16, 0, 0, waited);
        tile_valid_i = 1'b0;
        check_eq("full_busy", 64'(busy_o), 64'(1));
        wait_done("full", SLOTS);
        check_eq("full_writes", 64'(write_cnt - w0), 64'(64));
        check_eq("full_pulses", 64'(done_cnt - d0), 64'(1));
        check_eq("full_idle",   64'(busy_o), 64'(0));

        // Edge tile: only 2x4 corner in bounds, addr 96..99 and 116..119.
        w0 = write_cnt;
        send_tile(6, 20, 4, 16, waited);
        tile_valid_i = 1'b0;
        wait_done("edge", SLOTS);
        check_eq("edge_writes", 64'(write_cnt - w0), 64'(8));

        // Back-pressure: gnt low 3 cycles while slot (0,5) is presented.
        send_tile(16, 16, 0, 0, waited);
        tile_valid_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1 sram_c_gnt_i = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk_i);
            check_eq("stall_addr",  64'(sram_c_addr_o),  64'(5));
            check_eq("stall_wdata", 64'(sram_c_wdata_o), 64'(last_tile[0][5]));
            check_eq("stall_we",    64'(sram_c_we_o),    64'(1));
            @(posedge clk_i);
        end
        #1 sram_c_gnt_i = 1'b1;
        wait_done("stall", SLOTS + 3);

        // Back-to-back: second tile waits exactly until the last-slot cycle.
        d0 = done_cnt;
        send_tile(16, 16, 0, 0, waited);
        w0 = cap_cyc;
        send_tile(16, 16, 0, 0, waited);
        tile_valid_i = 1'b0;
        check_eq("b2b_ready_low_cycles", 64'(waited), 64'(SLOTS - 1));
        check_eq("b2b_capture_gap",      64'(cap_cyc - w0), 64'(SLOTS));
        wait_done("b2b", SLOTS);
        check_eq("b2b_pulses", 64'(done_cnt - d0), 64'(2));

        // Reset while slot 10 is presented: tile discarded, no done pulse.
        w0 = write_cnt; d0 = done_cnt;
        send_tile(16, 16, 0, 0, waited);
        tile_valid_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1;
        check_eq("pre_rst_addr", 64'(sram_c_addr_o), 64'(10));
        rst_ni = 1'b0;
        #1;
        check_eq("mid_rst_we",    64'(sram_c_we_o),  64'(0));
        check_eq("mid_rst_busy",  64'(busy_o),       64'(0));
        check_eq("mid_rst_ready", 64'(tile_ready_o), 64'(1));
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        #1;
        check_eq("post_rst_ready", 64'(tile_ready_o), 64'(1));
        check_eq("post_rst_busy",  64'(busy_o),       64'(0));
        repeat (80) @(posedge clk_i);
        #1;
        check_eq("rst_writes_after", 64'(write_cnt - w0), 64'(10));
        check_eq("rst_no_done",      64'(done_cnt - d0),  64'(0));

        // All slots out of bounds: full walk, zero writes, one pulse.
        w0 = write_cnt; d0 = done_cnt;
        send_tile(8, 16, 8, 0, waited);
        tile_valid_i = 1'b0;
        check_eq("oob_we", 64'(sram_c_we_o), 64'(0));
        wait_done("oob", SLOTS);
        check_eq("oob_writes", 64'(write_cnt - w0), 64'(0));
        check_eq("oob_pulses", 64'(done_cnt - d0), 64'(1));

        // Random in-range sizes and bases, random gnt.
        for (int t = 0; t < 3; t++) begin
            int m, n, rb, cb, inb;
            m  = $urandom_range(1, 40);
            n  = $urandom_range(1, 40);
            rb = $urandom_range(0, 40);
            cb = $urandom_range(0, 40);
            inb = 0;
            for (int r = 0; r < RP; r++)
                for (int c = 0; c < CP; c++)
                    if ((rb + r) < m && (cb + c) < n) inb++;
            w0 = write_cnt;
            send_tile(m, n, rb, cb, waited);
            tile_valid_i = 1'b0;
            for (int k = 0; k < 400 && busy_o; k++) begin
                sram_c_gnt_i = 1'($urandom_range(0, 1));
                @(posedge clk_i);
                #1;
            end
            sram_c_gnt_i = 1'b1;
            repeat (2) @(posedge clk_i);
            #1;
            check_eq("rand_writes", 64'(write_cnt - w0), 64'(inb));
        end

        check_eq("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
